// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: multi-cycle FSM driving one synchronous single-port RAM.
// Memory controls and the retire strobe are decoded from the state register.
module acc_cpu_core #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  halted,
  output logic                  retire
);

  typedef enum logic [3:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_IRD, S_IWAIT,
    S_RD, S_WAIT, S_EXEC, S_WRITE, S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_LOADI = 4'h8;
  localparam logic [3:0] OP_SKIP  = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_CLEAR = 4'hB;
  localparam logic [3:0] OP_JUMPI = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   ir, mbr;
  logic [ADDR_WIDTH-1:0]   mar;
  // Cleared by reset so the cycle after a reset edge issues no fetch.
  logic                    started;

  logic [3:0]              opcode;
  logic [ADDR_WIDTH-1:0]   x;
  logic [1:0]              cond;
  logic                    skip;

  assign opcode    = ir[DATA_WIDTH-1:DATA_WIDTH-4];
  assign x         = ir[ADDR_WIDTH-1:0];
  assign cond      = ir[11:10];
  assign mem_wdata = ac;

  // Signed SKIPCOND condition on the current accumulator.
  always_comb begin
    skip = 1'b0;
    case (cond)
      2'b00:   skip = ac[DATA_WIDTH-1];
      2'b01:   skip = (ac == '0);
      2'b10:   skip = !ac[DATA_WIDTH-1] && (ac != '0);
      default: skip = 1'b0;
    endcase
  end

  // Next state plus memory controls, retire and halted decoded from state.
  always_comb begin
    state_nxt = state;
    mem_cs    = 1'b0;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: if (started) begin
        mem_cs    = 1'b1;
        mem_oe    = 1'b1;
        state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: state_nxt = S_DECODE;
      S_DECODE: case (opcode)
        OP_STORE:                                 state_nxt = S_WRITE;
        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR:   state_nxt = S_RD;
        OP_LOADI, OP_JUMPI:                       state_nxt = S_IRD;
        OP_HALT: begin
          state_nxt = S_HALT;
          retire    = 1'b1;
        end
        default: begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      endcase
      S_IRD: begin
        mem_cs    = 1'b1;
        mem_oe    = 1'b1;
        mem_addr  = x;
        state_nxt = S_IWAIT;
      end
      S_IWAIT: if (opcode == OP_JUMPI) begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end else begin
        state_nxt = S_RD;
      end
      S_RD: begin
        mem_cs    = 1'b1;
        mem_oe    = 1'b1;
        mem_addr  = mar;
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_EXEC;
      S_EXEC: begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_WRITE: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = x;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State register and datapath updates (rst overrides resume and everything else).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      started <= 1'b0;
      pc      <= RESET_PC;
      ac      <= '0;
      ir      <= '0;
      mbr     <= '0;
      mar     <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      case (state)
        S_FETCH_WAIT: begin
          ir <= mem_rdata;
          pc <= pc + 1'b1;
        end
        S_DECODE: begin
          mar <= x;
          case (opcode)
            OP_NOT:   ac <= ~ac;
            OP_SKIP:  if (skip) pc <= pc + 1'b1;
            OP_JUMP:  pc <= x;
            OP_CLEAR: ac <= '0;
            default:  ;
          endcase
        end
        S_IWAIT: begin
          if (opcode == OP_JUMPI) pc  <= mem_rdata[ADDR_WIDTH-1:0];
          else                    mar <= mem_rdata[ADDR_WIDTH-1:0];
        end
        S_WAIT: mbr <= mem_rdata;
        S_EXEC: case (opcode)
          OP_LOAD, OP_LOADI: ac <= mbr;
          OP_ADD:            ac <= ac + mbr;
          OP_SUB:            ac <= ac - mbr;
          OP_AND:            ac <= ac & mbr;
          OP_OR:             ac <= ac | mbr;
          default:           ;
        endcase
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: RAM model, instruction-level reference model,
// directed programs and randomized memory images.
module tb_acc_cpu_core;
  logic        clk = 1'b0, rst = 1'b1, resume = 1'b0, ld = 1'b0;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, ac;
  logic        mem_cs, mem_we, mem_oe, halted, retire;

  logic [15:0] mem   [0:4095];   // RAM contents seen by the DUT
  logic [15:0] m_mem [0:4095];   // reference model memory (also the load image)
  logic [11:0] m_pc;
  logic [15:0] m_ac;
  int n_cmp = 0, n_bad = 0;

  acc_cpu_core #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .RESET_PC(12'h100)) dut (
    .clk(clk), .rst(rst), .resume(resume), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .pc(pc), .ac(ac), .halted(halted), .retire(retire));

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid the cycle after the request; ld copies the image.
  always @(posedge clk) begin
    if (ld) mem <= m_mem;
    else begin
      if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
    end
  end

  // One architectural instruction at the ISA level; returns its cycle cost.
  task automatic model_step(output int cyc, output bit hlt);
    logic [15:0] ir;
    logic [11:0] x;
    logic signed [15:0] sac;
    bit sk;
    ir = m_mem[m_pc];
    m_pc = m_pc + 12'd1;
    x = ir[11:0];
    sac = m_ac;
    hlt = 0;
    cyc = 3;
    case (ir[15:12])
      4'h1: begin m_ac = m_mem[x]; cyc = 6; end
      4'h2: begin m_mem[x] = m_ac; cyc = 4; end
      4'h3: begin m_ac = m_ac + m_mem[x]; cyc = 6; end
      4'h4: begin m_ac = m_ac - m_mem[x]; cyc = 6; end
      4'h5: begin m_ac = m_ac & m_mem[x]; cyc = 6; end
      4'h6: begin m_ac = m_ac | m_mem[x]; cyc = 6; end
      4'h7: m_ac = ~m_ac;
      4'h8: begin m_ac = m_mem[m_mem[x][11:0]]; cyc = 8; end
      4'h9: begin
        case (ir[11:10])
          2'b00:   sk = (sac < 0);
          2'b01:   sk = (sac == 0);
          2'b10:   sk = (sac > 0);
          default: sk = 0;
        endcase
        if (sk) m_pc = m_pc + 12'd1;
      end
      4'hA: m_pc = x;
      4'hB: m_ac = 16'h0;
      4'hC: begin m_pc = m_mem[x][11:0]; cyc = 5; end
      4'hF: hlt = 1;
      default: ;
    endcase
  endtask

  task automatic begin_reset();
    rst = 1'b1;
    resume = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4096; i++) m_mem[i] = 16'h0;
  endtask

  task automatic load_and_release();
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    rst = 1'b0;
    m_pc = 12'h100;
    m_ac = 16'h0;
  endtask

  // Runs up to max_instr instructions, checking each against the model.
  // Returns at the FETCH cycle of the next instruction, or in HALT.
  task automatic run_prog(input int max_instr, input int n_resume, input int hold,
                          output int retired, output bit ended_halted, output int last_cyc);
    int w, cyc, ecyc;
    bit hlt;
    retired = 0; ended_halted = 0; last_cyc = 0; w = 0;
    while (!(mem_cs && mem_oe) && w < 8) begin @(negedge clk); w++; end
    n_cmp++;
    if (!(mem_cs && mem_oe)) begin
      n_bad++; $display("FAIL first_fetch: no read request after %0d cycles", w); return;
    end
    while (retired < max_instr) begin
      n_cmp++;
      if (mem_addr !== m_pc || mem_cs !== 1'b1 || mem_oe !== 1'b1 || mem_we !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch: addr=%h cs=%b oe=%b we=%b, want addr=%h cs=1 oe=1 we=0",
                 mem_addr, mem_cs, mem_oe, mem_we, m_pc);
      end
      cyc = 1;
      while (retire !== 1'b1 && cyc < 20) begin
        @(negedge clk); cyc++;
        n_cmp++;
        if (mem_we && mem_oe) begin n_bad++; $display("FAIL we_oe: both high at pc=%h", pc); end
      end
      n_cmp++;
      if (retire !== 1'b1) begin
        n_bad++; $display("FAIL retire_timeout: no retire within %0d cycles", cyc); return;
      end
      model_step(ecyc, hlt);
      retired++;
      last_cyc = cyc;
      n_cmp++;
      if (cyc != ecyc) begin
        n_bad++; $display("FAIL cycles: got %0d want %0d (next pc %h)", cyc, ecyc, m_pc);
      end
      @(negedge clk);
      n_cmp++;
      if (pc !== m_pc || ac !== m_ac || halted !== hlt) begin
        n_bad++;
        $display("FAIL arch_state: pc=%h ac=%h halted=%b, want pc=%h ac=%h halted=%b",
                 pc, ac, halted, m_pc, m_ac, hlt);
      end
      if (hlt) begin
        if (n_resume == 0) begin ended_halted = 1; return; end
        n_resume--;
        repeat (hold) begin
          n_cmp++;
          if (mem_cs || mem_we || mem_oe || !halted) begin
            n_bad++;
            $display("FAIL halt_idle: cs=%b we=%b oe=%b halted=%b, want 0 0 0 1",
                     mem_cs, mem_we, mem_oe, halted);
          end
          @(negedge clk);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    begin_reset();
    m_mem[12'h100] = 16'h7000;  // NOT
    m_mem[12'h101] = 16'h1150;  // LOAD 0x150
    m_mem[12'h102] = 16'h2151;  // STORE 0x151
    m_mem[12'h150] = 16'h1234;
    n_cmp++;
    if (pc !== 12'h100 || ac !== 16'h0 || halted || retire || mem_cs || mem_we || mem_oe) begin
      n_bad++;
      $display("FAIL reset_values: pc=%h ac=%h halted=%b retire=%b cs=%b we=%b oe=%b",
               pc, ac, halted, retire, mem_cs, mem_we, mem_oe);
    end
    load_and_release();
    repeat (7) @(negedge clk);   // now in the RD cycle of LOAD
    n_cmp++;
    if (ac !== 16'hFFFF) begin n_bad++; $display("FAIL pre_reset_ac: got %h want ffff", ac); end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
    end
    n_cmp++;
    if (pc !== 12'h100 || ac !== 16'h0 || halted || retire || mem_cs || mem_oe) begin
      n_bad++;
      $display("FAIL midload_reset: pc=%h ac=%h halted=%b retire=%b cs=%b oe=%b, want 100 0 0 0 0 0",
               pc, ac, halted, retire, mem_cs, mem_oe);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!(mem_cs && mem_oe) || mem_addr !== 12'h100) begin
      n_bad++;
      $display("FAIL post_reset_fetch: cs=%b oe=%b addr=%h want 1 1 100", mem_cs, mem_oe, mem_addr);
    end
    repeat (8) begin
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_bad++; $display("FAIL post_reset_we: got %b want 0", mem_we); end
    end
  endtask

  task automatic test_multiply();
    int ret, lc; bit eh;
    begin_reset();
    m_mem[12'h100] = 16'h110D; m_mem[12'h101] = 16'h310A; m_mem[12'h102] = 16'h210D;
    m_mem[12'h103] = 16'h110C; m_mem[12'h104] = 16'h310B; m_mem[12'h105] = 16'h210C;
    m_mem[12'h106] = 16'h9400; m_mem[12'h107] = 16'hA100; m_mem[12'h108] = 16'hF000;
    m_mem[12'h10A] = 16'd7;    m_mem[12'h10B] = 16'hFFFF; m_mem[12'h10C] = 16'd5;
    load_and_release();
    run_prog(100, 0, 0, ret, eh, lc);
    n_cmp++;
    if (mem[12'h10D] !== 16'h0023 || !eh || halted !== 1'b1 || ret != 40) begin
      n_bad++;
      $display("FAIL multiply: M[10D]=%h halted=%b retired=%0d, want 0023 1 40",
               mem[12'h10D], halted, ret);
    end
  endtask

  task automatic test_signed_skip();
    int ret, lc; bit eh;
    begin_reset();
    m_mem[12'h100] = 16'h1110; m_mem[12'h101] = 16'h9000; m_mem[12'h102] = 16'hB000;
    m_mem[12'h103] = 16'h9800; m_mem[12'h104] = 16'h7000; m_mem[12'h105] = 16'hF000;
    m_mem[12'h110] = 16'h8000;
    load_and_release();
    run_prog(20, 0, 0, ret, eh, lc);
    n_cmp++;
    if (ac !== 16'h7FFF || pc !== 12'h106 || ret != 5) begin
      n_bad++;
      $display("FAIL signed_skip: ac=%h pc=%h retired=%0d, want 7fff 106 5", ac, pc, ret);
    end
  endtask

  task automatic test_indirect();
    int ret, lc; bit eh;
    begin_reset();
    m_mem[12'h100] = 16'h8120; m_mem[12'h101] = 16'hC120;
    m_mem[12'h120] = 16'h0130; m_mem[12'h130] = 16'hBEEF; m_mem[12'h131] = 16'hF000;
    load_and_release();
    run_prog(1, 0, 0, ret, eh, lc);
    n_cmp++;
    if (ac !== 16'hBEEF || lc != 8) begin
      n_bad++; $display("FAIL loadi: ac=%h cycles=%0d, want beef 8", ac, lc);
    end
    run_prog(1, 0, 0, ret, eh, lc);
    n_cmp++;
    if (pc !== 12'h130 || lc != 5) begin
      n_bad++; $display("FAIL jumpi: pc=%h cycles=%0d, want 130 5", pc, lc);
    end
    run_prog(10, 0, 0, ret, eh, lc);
    n_cmp++;
    if (ac !== 16'h0 || pc !== 12'h132 || !eh) begin
      n_bad++; $display("FAIL indirect_tail: ac=%h pc=%h halted=%b, want 0 132 1", ac, pc, eh);
    end
  endtask

  task automatic test_wrap();
    int ret, lc; bit eh;
    begin_reset();
    m_mem[12'h100] = 16'h1140; m_mem[12'h101] = 16'h3141; m_mem[12'h102] = 16'h2142;
    m_mem[12'h103] = 16'h1143; m_mem[12'h104] = 16'h3141; m_mem[12'h105] = 16'h2144;
    m_mem[12'h106] = 16'hAFFF; m_mem[12'hFFF] = 16'h7000; m_mem[12'h000] = 16'hF000;
    m_mem[12'h140] = 16'h7FFF; m_mem[12'h141] = 16'h0001; m_mem[12'h143] = 16'hFFFF;
    m_mem[12'h144] = 16'h5555;
    load_and_release();
    run_prog(20, 0, 0, ret, eh, lc);
    n_cmp++;
    if (mem[12'h142] !== 16'h8000 || mem[12'h144] !== 16'h0000) begin
      n_bad++;
      $display("FAIL add_wrap: M[142]=%h M[144]=%h, want 8000 0000", mem[12'h142], mem[12'h144]);
    end
    n_cmp++;
    if (pc !== 12'h001 || ac !== 16'hFFFF || !eh) begin
      n_bad++; $display("FAIL pc_wrap: pc=%h ac=%h halted=%b, want 001 ffff 1", pc, ac, eh);
    end
  endtask

  task automatic test_halt_resume();
    int ret, lc; bit eh;
    begin_reset();
    m_mem[12'h100] = 16'h7000; m_mem[12'h101] = 16'hB000; m_mem[12'h102] = 16'h7000;
    m_mem[12'h103] = 16'h0000; m_mem[12'h104] = 16'h7000; m_mem[12'h105] = 16'hF000;
    m_mem[12'h106] = 16'h7000; m_mem[12'h107] = 16'hF000;
    load_and_release();
    run_prog(50, 1, 10, ret, eh, lc);
    n_cmp++;
    if (ret != 8 || ac !== 16'hFFFF || pc !== 12'h108 || !eh) begin
      n_bad++;
      $display("FAIL halt_resume: retired=%0d ac=%h pc=%h halted=%b, want 8 ffff 108 1",
               ret, ac, pc, eh);
    end
  endtask

  task automatic test_random();
    int ret, lc, diffs, first;
    bit eh;
    for (int t = 0; t < 6; t++) begin
      begin_reset();
      for (int i = 0; i < 4096; i++) m_mem[i] = 16'($urandom);
      load_and_release();
      run_prog(120, 4, $urandom_range(1, 4), ret, eh, lc);
      diffs = 0; first = -1;
      for (int i = 0; i < 4096; i++)
        if (mem[i] !== m_mem[i]) begin diffs++; if (first < 0) first = i; end
      n_cmp++;
      if (diffs != 0) begin
        n_bad++;
        $display("FAIL random_mem trial %0d: %0d words differ, first at %h (got %h want %h)",
                 t, diffs, first[11:0], mem[first[11:0]], m_mem[first[11:0]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_signed_skip();
    test_indirect();
    test_wrap();
    test_halt_resume();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
